// File: rtl/ff_bank_pkg.sv
// Shared mode encodings for the multimode flop bank.
package ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_D  = 2'b00;
    localparam mode_t MODE_T  = 2'b01;
    localparam mode_t MODE_JK = 2'b10;
    localparam mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/ff_bit_next.sv
// Combinational next-state function for one flop bit in D, T, JK or SR mode.
module ff_bit_next
    import ff_bank_pkg::*;
(
    input  logic       i_q,
    input  logic       i_x,
    input  logic       i_y,
    input  logic [1:0] i_mode,
    output logic       o_q_next,
    output logic       o_illegal
);

    mode_t w_mode;
    assign w_mode = mode_t'(i_mode);

    always_comb begin
        o_q_next  = i_q;
        o_illegal = 1'b0;
        case (w_mode)
            MODE_D:  o_q_next = i_x;
            MODE_T:  o_q_next = i_q ^ i_x;
            MODE_JK: begin
                case ({i_x, i_y})
                    2'b01:   o_q_next = 1'b0;
                    2'b10:   o_q_next = 1'b1;
                    2'b11:   o_q_next = ~i_q;
                    default: o_q_next = i_q;
                endcase
            end
            MODE_SR: begin
                case ({i_x, i_y})
                    2'b10:   o_q_next = 1'b1;
                    2'b01:   o_q_next = 1'b0;
                    // S=R=1 is flagged; the bit keeps its value
                    2'b11:   o_illegal = 1'b1;
                    default: o_q_next = i_q;
                endcase
            end
            default: o_q_next = i_q;
        endcase
    end

endmodule

// File: rtl/ff_bank_multimode.sv
// WIDTH-bit flop bank with global D/T/JK/SR mode, change pulses, saturating
// change counter and sticky illegal-SR flag.
module ff_bank_multimode
    import ff_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qbar,
    output logic [WIDTH-1:0] o_changed,
    output logic [CNT_W-1:0] o_chg_cnt,
    output logic             o_err
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_changed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [WIDTH-1:0] w_bit_next;
    logic [WIDTH-1:0] w_illegal;
    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_err_set;
    logic             w_any_change;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        ff_bit_next u_bit (
            .i_q       (r_q[gi]),
            .i_x       (i_a[gi]),
            .i_y       (i_b[gi]),
            .i_mode    (i_mode),
            .o_q_next  (w_bit_next[gi]),
            .o_illegal (w_illegal[gi])
        );
    end

    always_comb begin
        w_q_next = r_q;
        if (i_clr) begin
            w_q_next = RESET_VAL;
        end else if (i_en) begin
            w_q_next = w_bit_next;
        end
    end

    assign w_any_change = (w_q_next != r_q);

    // Clear beats increment; the counter sticks at all-ones
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clr) begin
            w_cnt_next = '0;
        end else if (w_any_change && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    assign w_err_set = i_en && !i_clr && (mode_t'(i_mode) == MODE_SR) && (|w_illegal);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q       <= RESET_VAL;
            r_changed <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_q_next ^ r_q;
            r_cnt     <= w_cnt_next;
            r_err     <= w_err_set || (r_err && !i_err_clr);
        end
    end

    assign o_q       = r_q;
    assign o_qbar    = ~r_q;
    assign o_changed = r_changed;
    assign o_chg_cnt = r_cnt;
    assign o_err     = r_err;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Bench for ff_bank_multimode: directed literal checks plus randomized run
// against a characteristic-equation model of two differently parameterised banks.
module tb_ff_bank_multimode;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       err_clr;

    logic [7:0]  q0, qb0, ch0;
    logic [15:0] cnt0;
    logic        err0;
    logic [7:0]  q1, qb1, ch1;
    logic [1:0]  cnt1;
    logic        err1;

    int n_vec = 0;
    int n_err = 0;

    ff_bank_multimode #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5),
        .CNT_W     (16)
    ) dut0 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_clr     (clr),
        .i_mode    (mode),
        .i_a       (a),
        .i_b       (b),
        .i_err_clr (err_clr),
        .o_q       (q0),
        .o_qbar    (qb0),
        .o_changed (ch0),
        .o_chg_cnt (cnt0),
        .o_err     (err0)
    );

    ff_bank_multimode #(
        .WIDTH     (8),
        .RESET_VAL (8'h00),
        .CNT_W     (2)
    ) dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_clr     (clr),
        .i_mode    (mode),
        .i_a       (a),
        .i_b       (b),
        .i_err_clr (err_clr),
        .o_q       (q1),
        .o_qbar    (qb1),
        .o_changed (ch1),
        .o_chg_cnt (cnt1),
        .o_err     (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flop characteristic equations on whole vectors
    function automatic logic [7:0] next_q(input logic [1:0] md, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] q);
        logic [7:0] ill;
        ill = x & y;
        case (md)
            2'd0:    return x;
            2'd1:    return q ^ x;
            2'd2:    return (x & ~q) | (~y & q);
            default: return (ill & q) | (~ill & (x | (~y & q)));
        endcase
    endfunction

    logic [7:0] m_rv  [2];
    int         m_max [2];
    logic [7:0] m_q   [2];
    logic [7:0] m_chg [2];
    int         m_cnt [2];
    logic       m_err [2];

    initial begin
        m_rv[0]  = 8'hA5;
        m_rv[1]  = 8'h00;
        m_max[0] = 65535;
        m_max[1] = 3;
    end

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_q[d]   <= m_rv[d];
                m_chg[d] <= 8'h00;
                m_cnt[d] <= 0;
                m_err[d] <= 1'b0;
            end else begin
                logic [7:0] nq;
                nq = clr ? m_rv[d] : (en ? next_q(mode, a, b, m_q[d]) : m_q[d]);
                m_q[d]   <= nq;
                m_chg[d] <= nq ^ m_q[d];
                if (clr) m_cnt[d] <= 0;
                else if (nq != m_q[d] && m_cnt[d] < m_max[d]) m_cnt[d] <= m_cnt[d] + 1;
                m_err[d] <= (en && !clr && mode == 2'd3 && (|(a & b))) || (m_err[d] && !err_clr);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m0_q",    {24'd0, q0},   {24'd0, m_q[0]});
            chk("m0_qbar", {24'd0, qb0},  {24'd0, ~m_q[0]});
            chk("m0_chg",  {24'd0, ch0},  {24'd0, m_chg[0]});
            chk("m0_cnt",  {16'd0, cnt0}, m_cnt[0]);
            chk("m0_err",  {31'd0, err0}, {31'd0, m_err[0]});
            chk("m1_q",    {24'd0, q1},   {24'd0, m_q[1]});
            chk("m1_qbar", {24'd0, qb1},  {24'd0, ~m_q[1]});
            chk("m1_chg",  {24'd0, ch1},  {24'd0, m_chg[1]});
            chk("m1_cnt",  {30'd0, cnt1}, m_cnt[1]);
            chk("m1_err",  {31'd0, err1}, {31'd0, m_err[1]});
        end
    end

    // Drive inputs at a falling edge, let one rising edge pass, return at next falling edge
    task automatic step(input logic e, input logic c, input logic [1:0] md,
                        input logic [7:0] x, input logic [7:0] y, input logic ec);
        en = e; clr = c; mode = md; a = x; b = y; err_clr = ec;
        @(negedge clk);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_q"},    {24'd0, q0},   32'hA5);
        chk({tag, "_qbar"}, {24'd0, qb0},  32'h5A);
        chk({tag, "_chg"},  {24'd0, ch0},  32'h00);
        chk({tag, "_cnt"},  {16'd0, cnt0}, 32'h0);
        chk({tag, "_err"},  {31'd0, err0}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b1; en = 0; clr = 0; mode = 0; a = 0; b = 0; err_clr = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset0("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 1, 2'd0, 8'h00, 8'h00, 0);
        chk("clr_q", {24'd0, q0}, 32'hA5);
        chk("clr_cnt", {16'd0, cnt0}, 32'h0);
        step(1, 0, 2'd0, 8'h00, 8'h00, 0);
        chk("d_chg", {24'd0, ch0}, 32'hA5);
        chk("d_cnt", {16'd0, cnt0}, 32'h1);

        step(1, 0, 2'd1, 8'hFF, 8'h00, 0);
        chk("t1_q", {24'd0, q0}, 32'hFF);
        chk("t1_chg", {24'd0, ch0}, 32'hFF);
        step(1, 0, 2'd1, 8'hFF, 8'h00, 0);
        chk("t2_q", {24'd0, q0}, 32'h00);
        step(1, 0, 2'd1, 8'hFF, 8'h00, 0);
        chk("t3_q", {24'd0, q0}, 32'hFF);
        chk("t3_cnt", {16'd0, cnt0}, 32'h4);
        step(1, 0, 2'd1, 8'h00, 8'h00, 0);
        chk("t0_q", {24'd0, q0}, 32'hFF);
        chk("t0_chg", {24'd0, ch0}, 32'h00);
        chk("t0_cnt", {16'd0, cnt0}, 32'h4);

        step(1, 0, 2'd0, 8'h0F, 8'h00, 0);
        step(1, 0, 2'd2, 8'hF0, 8'h3C, 0);
        chk("jk_q", {24'd0, q0}, 32'hF3);
        chk("jk_qbar", {24'd0, qb0}, 32'h0C);
        chk("jk_chg", {24'd0, ch0}, 32'hFC);

        step(1, 0, 2'd0, 8'h00, 8'h00, 0);
        step(1, 0, 2'd3, 8'h81, 8'h01, 0);
        chk("sr_q", {24'd0, q0}, 32'h80);
        chk("sr_err", {31'd0, err0}, 32'h1);
        step(1, 0, 2'd3, 8'h00, 8'h00, 1);
        chk("sr_errclr", {31'd0, err0}, 32'h0);
        chk("sr_hold", {24'd0, q0}, 32'h80);
        step(1, 0, 2'd3, 8'h01, 8'h01, 1);
        chk("sr_setwins", {31'd0, err0}, 32'h1);

        step(1, 0, 2'd0, 8'h33, 8'h00, 0);
        step(1, 1, 2'd0, 8'hFF, 8'h00, 0);
        chk("clren_q", {24'd0, q1}, 32'h00);
        chk("clren_cnt", {30'd0, cnt1}, 32'h0);
        chk("clren_chg", {24'd0, ch1}, 32'h33);

        step(1, 0, 2'd0, 8'hFF, 8'h00, 0);
        chk("sat1", {30'd0, cnt1}, 32'h1);
        step(1, 0, 2'd0, 8'h00, 8'h00, 0);
        chk("sat2", {30'd0, cnt1}, 32'h2);
        step(1, 0, 2'd0, 8'hFF, 8'h00, 0);
        chk("sat3", {30'd0, cnt1}, 32'h3);
        step(1, 0, 2'd0, 8'h00, 8'h00, 0);
        chk("sat4", {30'd0, cnt1}, 32'h3);
        step(1, 0, 2'd0, 8'hFF, 8'h00, 0);
        chk("sat5", {30'd0, cnt1}, 32'h3);

        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(3) != 0);
            clr     = ($urandom_range(15) == 0);
            mode    = 2'($urandom_range(3));
            a       = 8'($urandom);
            b       = 8'($urandom);
            err_clr = ($urandom_range(3) == 0);
            if ($urandom_range(99) == 0) begin
                #3 rst_n = 1'b0;
                #1 chk_reset0("rst_mid");
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
